// File: rtl/d_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache for the rv32i memory stage.
// Loads refill whole lines one beat at a time; stores always go to memory and update the line only on a hit.
`timescale 1ns/1ps

package rv32i_pkg;
  localparam int DPW = 32;
  localparam int ADW = 32;
endpackage

module d_cache_dm_lane (
  input  logic [7:0] cur,
  input  logic [7:0] wr,
  input  logic       en,
  output logic [7:0] q
);
  assign q = en ? wr : cur;
endmodule

module d_cache_dm
  import rv32i_pkg::*;
#(
  parameter int LineWords = 4,
  parameter int NumLines  = 16,
  parameter int CntWidth  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [DPW-1:0]      req_addr,
  input  logic [DPW-1:0]      req_wdata,
  input  logic [3:0]          req_be,
  input  logic                flush,
  output logic                stall,
  output logic                rsp_valid,
  output logic [DPW-1:0]      rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [DPW-1:0]      mem_req_addr,
  output logic [DPW-1:0]      mem_req_wdata,
  output logic [3:0]          mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DPW-1:0]      mem_rsp_rdata,
  output logic [CntWidth-1:0] hit_count,
  output logic [CntWidth-1:0] miss_count
);
  localparam int OW = $clog2(LineWords);
  localparam int IW = $clog2(NumLines);
  localparam int TW = DPW - 2 - OW - IW;

  typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_WAIT, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [NumLines-1:0] valid;
  logic [TW-1:0]       tags  [NumLines];
  logic [DPW-1:0]      lines [NumLines][LineWords];

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  assign req_off = req_addr[OW+1:2];
  assign req_idx = req_addr[OW+IW+1:OW+2];
  assign req_tag = req_addr[DPW-1:OW+IW+2];

  logic unused;
  assign unused = ^req_addr[1:0];

  logic           hit;
  logic [DPW-1:0] hit_word, merged;
  assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);
  assign hit_word = lines[req_idx][req_off];

  for (genvar b = 0; b < 4; b++) begin : g_lane
    d_cache_dm_lane u_lane (
      .cur(hit_word[8*b +: 8]),
      .wr (req_wdata[8*b +: 8]),
      .en (req_be[b]),
      .q  (merged[8*b +: 8])
    );
  end

  // Request held for the duration of a miss or a store; word address only.
  logic           cap_we;
  logic [DPW-3:0] cap_waddr;
  logic [DPW-1:0] cap_wdata;
  logic [3:0]     cap_be;
  logic [OW-1:0]  beat;
  logic [OW-1:0]  cap_off;
  logic [IW-1:0]  cap_idx;
  logic [TW-1:0]  cap_tag;
  assign cap_off = cap_waddr[OW-1:0];
  assign cap_idx = cap_waddr[OW+IW-1:OW];
  assign cap_tag = cap_waddr[DPW-3:OW+IW];

  logic idle, do_flush, do_req, ld_hit, ld_miss, st, last_beat, fill;
  assign idle      = (state == IDLE);
  assign do_flush  = idle && flush;
  assign do_req    = idle && !flush && req_valid;
  assign ld_hit    = do_req && !req_we && hit;
  assign ld_miss   = do_req && !req_we && !hit;
  assign st        = do_req && req_we;
  assign last_beat = (beat == OW'(LineWords - 1));
  assign fill      = (state == REFILL_WAIT) && mem_rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    stall         = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = {cap_waddr, 2'b00};
    mem_req_wdata = cap_wdata;
    mem_req_be    = cap_be;
    case (state)
      IDLE: begin
        stall = flush || (req_valid && (req_we || !hit));
        if (ld_miss)  state_nxt = REFILL_REQ;
        else if (st)  state_nxt = WRITE;
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {cap_tag, cap_idx, beat, 2'b00};
        mem_req_be    = 4'hF;
        if (mem_req_ready) state_nxt = REFILL_WAIT;
      end
      REFILL_WAIT: if (mem_rsp_valid) state_nxt = last_beat ? DONE : REFILL_REQ;
      WRITE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) state_nxt = DONE;
      end
      DONE: begin
        stall     = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      beat       <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (do_flush) valid <= '0;
      if (ld_hit) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= hit_word;
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      // Line is invalid while being refilled so a torn line can never hit.
      if (ld_miss) begin
        valid[req_idx] <= 1'b0;
        beat           <= '0;
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
      if (fill) begin
        if (last_beat) valid[cap_idx] <= 1'b1;
        else           beat <= beat + 1'b1;
      end
      if (state == DONE && !cap_we) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= lines[cap_idx][cap_off];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_miss || st) begin
      cap_we    <= req_we;
      cap_waddr <= req_addr[DPW-1:2];
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (st && hit) lines[req_idx][req_off] <= merged;
      if (fill) begin
        lines[cap_idx][beat] <= mem_rsp_rdata;
        if (last_beat) tags[cap_idx] <= cap_tag;
      end
    end
  end
endmodule

// File: tb/tb_d_cache_dm.sv
// Scoreboard bench for d_cache_dm: memory model returns addr^KEY one cycle after each accepted read.
`timescale 1ns/1ps

module tb_d_cache_dm;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, flush = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic [3:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  d_cache_dm #(.LineWords(4), .NumLines(16), .CntWidth(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .flush(flush), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [31:0] exp_rsp[$];
  int checks = 0, errors = 0, n_reads = 0, n_writes = 0, late_req = 0;

  task automatic exp_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b0, base + 32'(4 * i), 32'h0, 4'h0});
  endtask

  // Memory responder plus scoreboard pop/compare, runs at negedge+1.
  task automatic model();
    logic        pend;
    logic [31:0] pend_data, r;
    int          late_done;
    mem_exp_t    e;
    pend = 1'b0; pend_data = '0; late_done = 0;
    forever begin
      @(negedge clk); #1;
      mem_rsp_valid = pend || (late_req != late_done);
      mem_rsp_rdata = pend ? pend_data : 32'hDEADBEEF;
      late_done = late_req;
      pend = 1'b0;
      if (rsp_valid) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++; $display("FAIL rsp_unexpected got=%h", rsp_rdata);
        end else begin
          r = exp_rsp.pop_front();
          if (rsp_rdata !== r) begin errors++; $display("FAIL rsp_data got=%h exp=%h", rsp_rdata, r); end
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (mem_req_we) n_writes++;
        else begin n_reads++; pend = 1'b1; pend_data = mem_req_addr ^ KEY; end
        if (exp_mem.size() == 0) begin
          errors++; $display("FAIL mem_unexpected we=%b addr=%h", mem_req_we, mem_req_addr);
        end else begin
          e = exp_mem.pop_front();
          if (mem_req_we !== e.we || mem_req_addr !== e.addr ||
              (e.we && (mem_req_wdata !== e.wdata || mem_req_be !== e.be))) begin
            errors++;
            $display("FAIL mem_req got we=%b addr=%h wd=%h be=%b exp we=%b addr=%h wd=%h be=%b",
                     mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be, e.we, e.addr, e.wdata, e.be);
          end
        end
      end
    end
  endtask

  task automatic finish_req(output int stalls, output logic rsp_now);
    stalls = 0;
    #3;
    while (stall && stalls < 200) begin @(negedge clk); #3; stalls++; end
    if (stall) begin checks++; errors++; $display("FAIL req_timeout stalls=%0d", stalls); end
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    rsp_now = rsp_valid;
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls, output logic rsp_now);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    finish_req(stalls, rsp_now);
  endtask

  task automatic load_miss(input logic [31:0] a, output int stalls);
    logic rn;
    exp_line({a[31:4], 4'h0});
    exp_rsp.push_back(a ^ KEY);
    access(1'b0, a, '0, '0, stalls, rn);
  endtask

  task automatic flush_cycle();
    @(negedge clk);
    flush = 1'b1;
    #3;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall got=%b exp=1", stall); end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if ({rsp_valid, mem_req_valid, hit_count, miss_count} !== 10'b0) begin
      errors++; $display("FAIL reset_ctl got rsp=%b mreq=%b hit=%0d miss=%0d exp all 0",
                         rsp_valid, mem_req_valid, hit_count, miss_count);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_load();
    int st, r0; logic rn;
    r0 = n_reads;
    exp_line(32'h40);
    exp_rsp.push_back(32'hA5A5A5E5);
    access(1'b0, 32'h40, '0, '0, st, rn);
    checks++; if (st != 9) begin errors++; $display("FAIL cold_stall got=%0d exp=9", st); end
    checks++; if (rn !== 1'b1) begin errors++; $display("FAIL cold_rsp_next got=%b exp=1", rn); end
    checks++; if (n_reads - r0 != 4) begin errors++; $display("FAIL cold_reads got=%0d exp=4", n_reads - r0); end
    checks++; if (miss_count !== 4'd1) begin errors++; $display("FAIL cold_miss got=%0d exp=1", miss_count); end
    r0 = n_reads;
    exp_rsp.push_back(32'hA5A5A5ED);
    access(1'b0, 32'h48, '0, '0, st, rn);
    checks++; if (st != 0 || rn !== 1'b1) begin errors++; $display("FAIL hit_timing got stall=%0d rsp=%b exp 0/1", st, rn); end
    checks++; if (n_reads != r0) begin errors++; $display("FAIL hit_reads got=%0d exp=0", n_reads - r0); end
    checks++; if (hit_count !== 4'd1) begin errors++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
  endtask

  task automatic test_store_hit();
    int st, w0; logic rn;
    w0 = n_writes;
    exp_mem.push_back('{1'b1, 32'h44, 32'h12345678, 4'b0011});
    access(1'b1, 32'h44, 32'h12345678, 4'b0011, st, rn);
    checks++; if (st != 2 || rn !== 1'b0) begin errors++; $display("FAIL store_timing got stall=%0d rsp=%b exp 2/0", st, rn); end
    checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL store_writes got=%0d exp=1", n_writes - w0); end
    exp_rsp.push_back(32'hA5A55678);
    access(1'b0, 32'h44, '0, '0, st, rn);
    checks++; if (st != 0 || hit_count !== 4'd2) begin errors++; $display("FAIL merge_hit got stall=%0d hit=%0d exp 0/2", st, hit_count); end
  endtask

  task automatic test_store_miss();
    int st, r0, w0; logic rn;
    r0 = n_reads; w0 = n_writes;
    exp_mem.push_back('{1'b1, 32'h200, 32'hCAFEF00D, 4'hF});
    access(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, st, rn);
    checks++; if (n_reads != r0 || n_writes - w0 != 1) begin
      errors++; $display("FAIL store_miss_traffic got reads=%0d writes=%0d exp 0/1", n_reads - r0, n_writes - w0);
    end
    load_miss(32'h200, st);
    checks++; if (st != 9 || miss_count !== 4'd2) begin errors++; $display("FAIL no_alloc got stall=%0d miss=%0d exp 9/2", st, miss_count); end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    int st, r0, m0;
    seq = '{32'h040, 32'h140, 32'h040};
    flush_cycle();
    r0 = n_reads; m0 = int'(miss_count);
    for (int i = 0; i < 3; i++) load_miss(seq[i], st);
    checks++; if (n_reads - r0 != 12) begin errors++; $display("FAIL conflict_reads got=%0d exp=12", n_reads - r0); end
    checks++; if (int'(miss_count) - m0 != 3) begin errors++; $display("FAIL conflict_miss got=%0d exp=3", int'(miss_count) - m0); end
  endtask

  task automatic test_flush();
    int st, m0; logic rn;
    m0 = int'(miss_count);
    exp_line(32'h40);
    exp_rsp.push_back(32'h40 ^ KEY);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; flush = 1'b1;
    #3;
    checks++; if (stall !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_prec got stall=%b rsp=%b exp 1/0", stall, rsp_valid); end
    @(negedge clk);
    flush = 1'b0;
    finish_req(st, rn);
    checks++; if (st != 9 || int'(miss_count) - m0 != 1) begin errors++; $display("FAIL flush_inval got stall=%0d dmiss=%0d exp 9/1", st, int'(miss_count) - m0); end
    flush_cycle();
    load_miss(32'h140, st);
    checks++; if (st != 9) begin errors++; $display("FAIL flush_reload got=%0d exp=9", st); end
  endtask

  task automatic test_backpressure();
    int st, r0, m0; logic rn;
    r0 = n_reads; m0 = int'(miss_count);
    exp_line(32'h40);
    exp_rsp.push_back(32'h40 ^ KEY);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    repeat (3) @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if ({mem_req_valid, stall, mem_req_addr} !== {2'b11, 32'h44}) begin
        errors++; $display("FAIL bp_hold got valid=%b stall=%b addr=%h exp 1/1/00000044", mem_req_valid, stall, mem_req_addr);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    finish_req(st, rn);
    checks++; if (rn !== 1'b1 || n_reads - r0 != 4 || int'(miss_count) - m0 != 1) begin
      errors++; $display("FAIL bp_done got rsp=%b reads=%0d dmiss=%0d exp 1/4/1", rn, n_reads - r0, int'(miss_count) - m0);
    end
  endtask

  task automatic test_back_to_back();
    int h0;
    h0 = int'(hit_count);
    exp_rsp.push_back(32'h40 ^ KEY);
    exp_rsp.push_back(32'h4C ^ KEY);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    #3;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall0 got=%b exp=0", stall); end
    @(negedge clk);
    req_addr = 32'h4C;
    #3;
    checks++; if (stall !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got stall=%b rsp=%b exp 0/1", stall, rsp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    checks++; if (rsp_valid !== 1'b1 || int'(hit_count) - h0 != 2) begin
      errors++; $display("FAIL b2b_rate got rsp=%b dhit=%0d exp 1/2", rsp_valid, int'(hit_count) - h0);
    end
  endtask

  task automatic test_saturate();
    int st; logic rn;
    for (int i = 0; i < 12; i++) begin
      exp_rsp.push_back(32'h48 ^ KEY);
      access(1'b0, 32'h48, '0, '0, st, rn);
    end
    checks++; if (hit_count !== 4'hF) begin errors++; $display("FAIL hit_sat got=%0d exp=15", hit_count); end
    for (int i = 0; i < 8; i++) load_miss((i % 2 == 0) ? 32'h300 : 32'h200, st);
    checks++; if (miss_count !== 4'hF || hit_count !== 4'hF) begin
      errors++; $display("FAIL miss_sat got miss=%0d hit=%0d exp 15/15", miss_count, hit_count);
    end
  endtask

  task automatic test_reset_mid_refill();
    int st, r0;
    flush_cycle();
    r0 = n_reads;
    exp_line(32'h40);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    repeat (6) @(negedge clk);
    checks++; if (n_reads - r0 != 3) begin errors++; $display("FAIL rst_point got reads=%0d exp=3", n_reads - r0); end
    rst = 1'b1; req_valid = 1'b0;
    exp_mem.delete();
    @(negedge clk);
    rst = 1'b0;
    late_req++;
    #3;
    checks++;
    if ({mem_req_valid, rsp_valid, stall, hit_count, miss_count} !== 11'b0) begin
      errors++; $display("FAIL rst_mid got mreq=%b rsp=%b stall=%b hit=%0d miss=%0d exp all 0",
                         mem_req_valid, rsp_valid, stall, hit_count, miss_count);
    end
    @(negedge clk);
    #3;
    checks++; if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL late_rsp got rsp=%b mreq=%b exp 0/0", rsp_valid, mem_req_valid); end
    r0 = n_reads;
    load_miss(32'h40, st);
    checks++; if (st != 9 || n_reads - r0 != 4 || miss_count !== 4'd1) begin
      errors++; $display("FAIL rst_refill got stall=%0d reads=%0d miss=%0d exp 9/4/1", st, n_reads - r0, miss_count);
    end
  endtask

  initial begin
    fork
      model();
    join_none
    test_reset();
    test_cold_load();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_mid_refill();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_rsp.size() != 0) begin
      errors++; $display("FAIL leftover got mem=%0d rsp=%0d exp 0/0", exp_mem.size(), exp_rsp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
